// File: rtl/codificador_pkg.sv
// Shared types, code-word constants and trit helpers for the trinary serial encoder.
package codificador_pkg;

   typedef enum logic [1:0] {OCIOSO, TRIT, SINC} estado_t;
   typedef enum logic [1:0] {T0, T1, TF} trit_t;

   localparam int unsigned ALPHA_MEIO = 16;   // alpha units per half-bit
   localparam int unsigned ALTO_CURTO = 4;    // high alphas in a short half-bit
   localparam int unsigned ALTO_LONGO = 12;   // high alphas in a long half-bit
   localparam int unsigned SINC_ALPHA = 128;  // alpha units in the sync gap
   localparam int unsigned N_TRITS    = 12;
   localparam int unsigned N_END      = 8;
   localparam int unsigned N_DADOS    = 4;

   localparam int unsigned ALPHA_W = $clog2(SINC_ALPHA);
   localparam int unsigned TRIT_W  = $clog2(N_TRITS);

   // Word contents frozen at word start
   typedef struct packed {
      logic [N_END-1:0]   end_01;
      logic [N_END-1:0]   end_f;
      logic [N_DADOS-1:0] dados;
   } palavra_t;

   // Trit for position idx: A0..A7 then D0..D3; float flag wins over the value bit
   function automatic trit_t seleciona_trit(input palavra_t p, input logic [TRIT_W-1:0] idx);
      trit_t t;
      if (idx < TRIT_W'(N_END)) begin
         if (p.end_f[idx[2:0]])       t = TF;
         else if (p.end_01[idx[2:0]]) t = T1;
         else                         t = T0;
      end else begin
         t = p.dados[idx[1:0]] ? T1 : T0;
      end
      return t;
   endfunction

   // Level inside a trit; pos[4] selects the half-bit, pos[3:0] the alpha within it
   function automatic logic nivel_trit(input trit_t t, input logic [4:0] pos);
      logic longo;
      longo = (t == T1) || ((t == TF) && pos[4]);
      return pos[3:0] < (longo ? 4'(ALTO_LONGO) : 4'(ALTO_CURTO));
   endfunction

endpackage

// File: rtl/divisor_alpha.sv
// Alpha prescaler: counts clk cycles while enabled, held at zero otherwise.
//   clk, rst_n   : clock, async active-low reset
//   en_i         : count enable (low clears the count)
//   tick_c       : one-cycle pulse in the last clk of each alpha unit
//   pre_tick_c   : one-cycle pulse in the clk just before tick_c
module divisor_alpha #(
   parameter int unsigned ALPHA_CICLOS = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   output logic tick_c,
   output logic pre_tick_c
);

   localparam int unsigned CNT_W = (ALPHA_CICLOS > 1) ? $clog2(ALPHA_CICLOS) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: clear when disabled, wrap at the end of each alpha
   always_comb begin
      cnt_d = cnt_q;
      if (!en_i)
         cnt_d = '0;
      else if (cnt_q == CNT_W'(ALPHA_CICLOS - 1))
         cnt_d = '0;
      else
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign tick_c     = en_i && (cnt_q == CNT_W'(ALPHA_CICLOS - 1));
   assign pre_tick_c = en_i && (cnt_q == CNT_W'(ALPHA_CICLOS - 2));

endmodule

// File: rtl/serializador_trit.sv
// Trinary encoder output stage: sends 8 address trits, 4 data trits and a sync gap
// as one serial code word on dout, timed in alpha units of ALPHA_CICLOS clk.
//   clk, rst_n  : clock, async active-low reset
//   A_01, A_F   : address bit values and float flags (A_01 ignored where A_F=1)
//   D           : data nibble
//   te          : transmit enable
//   dout        : serial code output
//   ocupado     : high while a word is in progress
//   fim_quadro  : one-cycle pulse in the last clk of each word
// Optional macro SERIALIZADOR_MIN4_EN: each activation sends at least 4 words.
module serializador_trit
   import codificador_pkg::*;
#(
   parameter int unsigned ALPHA_CICLOS = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] A_01,
   input  logic [7:0] A_F,
   input  logic [3:0] D,
   input  logic       te,
   output logic       dout,
   output logic       ocupado,
   output logic       fim_quadro
);

   localparam int unsigned TRIT_ALPHA = 2 * ALPHA_MEIO;

   estado_t             estado_q, estado_d;
   logic [ALPHA_W-1:0]  alpha_q, alpha_d;
   logic [TRIT_W-1:0]   trit_q, trit_d;
   palavra_t            palavra_q, palavra_d;
   logic                dout_q, dout_d;
   logic                ocupado_q, ocupado_d;
   logic                fim_q, fim_d;
   logic                inicia;
   logic                continua;
   logic                tick_c;
   logic                pre_tick_c;
   palavra_t            captura;

   divisor_alpha #(
      .ALPHA_CICLOS(ALPHA_CICLOS)
   ) u_divisor (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (estado_q != OCIOSO),
      .tick_c     (tick_c),
      .pre_tick_c (pre_tick_c)
   );

   // Value bits under a float flag are forced to 0 so X can never reach dout
   always_comb begin
      captura.end_01 = A_01 & ~A_F;
      captura.end_f  = A_F;
      captura.dados  = D;
   end

`ifdef SERIALIZADOR_MIN4_EN
   logic [1:0] palavras_q, palavras_d;

   assign continua = te || (palavras_q != 2'd3);

   // Words sent in this activation, saturating at 3
   always_comb begin
      palavras_d = palavras_q;
      if (inicia) begin
         if (estado_q == OCIOSO)      palavras_d = 2'd0;
         else if (palavras_q != 2'd3) palavras_d = palavras_q + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) palavras_q <= 2'd0;
      else        palavras_q <= palavras_d;
   end
`else
   assign continua = te;
`endif

   // Next state, counters, capture, and the registered output values
   always_comb begin
      estado_d  = estado_q;
      alpha_d   = alpha_q;
      trit_d    = trit_q;
      palavra_d = palavra_q;
      fim_d     = 1'b0;
      inicia    = 1'b0;

      unique case (estado_q)
         OCIOSO: begin
            if (te) inicia = 1'b1;
         end
         TRIT: begin
            if (tick_c) begin
               if (alpha_q == ALPHA_W'(TRIT_ALPHA - 1)) begin
                  alpha_d = '0;
                  if (trit_q == TRIT_W'(N_TRITS - 1)) begin
                     estado_d = SINC;
                     trit_d   = '0;
                  end else begin
                     trit_d = trit_q + TRIT_W'(1);
                  end
               end else begin
                  alpha_d = alpha_q + ALPHA_W'(1);
               end
            end
         end
         SINC: begin
            // Flag the next clk as the final one of the word
            fim_d = (alpha_q == ALPHA_W'(SINC_ALPHA - 1)) && pre_tick_c;
            if (tick_c) begin
               if (alpha_q == ALPHA_W'(SINC_ALPHA - 1)) begin
                  alpha_d = '0;
                  if (continua) inicia   = 1'b1;
                  else          estado_d = OCIOSO;
               end else begin
                  alpha_d = alpha_q + ALPHA_W'(1);
               end
            end
         end
         default: begin
            estado_d = OCIOSO;
            alpha_d  = '0;
            trit_d   = '0;
         end
      endcase

      if (inicia) begin
         estado_d  = TRIT;
         alpha_d   = '0;
         trit_d    = '0;
         palavra_d = captura;
      end

      ocupado_d = (estado_d != OCIOSO);

      // dout follows the position the counters will hold after this edge
      unique case (estado_d)
         TRIT:    dout_d = nivel_trit(seleciona_trit(palavra_d, trit_d), alpha_d[4:0]);
         SINC:    dout_d = (alpha_d < ALPHA_W'(ALTO_CURTO));
         default: dout_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado_q  <= OCIOSO;
         alpha_q   <= '0;
         trit_q    <= '0;
         palavra_q <= '0;
         dout_q    <= 1'b0;
         ocupado_q <= 1'b0;
         fim_q     <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         alpha_q   <= alpha_d;
         trit_q    <= trit_d;
         palavra_q <= palavra_d;
         dout_q    <= dout_d;
         ocupado_q <= ocupado_d;
         fim_q     <= fim_d;
      end
   end

   assign dout       = dout_q;
   assign ocupado    = ocupado_q;
   assign fim_quadro = fim_q;

endmodule

// File: tb/tb_serializador_trit.sv
// Directed bench for serializador_trit with ALPHA_CICLOS=2 (one word = 1024 clk).
module tb_serializador_trit;

   localparam int unsigned AC   = 2;
   localparam int          PAL  = 1024;
   localparam int          MAXC = 4200;
`ifdef SERIALIZADOR_MIN4_EN
   localparam int NW1 = 4;
   localparam int NW5 = 4;
`else
   localparam int NW1 = 1;
   localparam int NW5 = 3;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] A_01;
   logic [7:0] A_F;
   logic [3:0] D;
   logic       te;
   logic       dout;
   logic       ocupado;
   logic       fim_quadro;

   int   n_assert = 0;
   int   n_falha  = 0;
   logic onda [MAXC];
   logic ocup [MAXC];
   logic fim  [MAXC];
   int   exp_t [12];   // expected trits: 0, 1, 2=F

   always #5 clk = ~clk;

   serializador_trit #(.ALPHA_CICLOS(AC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .A_01       (A_01),
      .A_F        (A_F),
      .D          (D),
      .te         (te),
      .dout       (dout),
      .ocupado    (ocupado),
      .fim_quadro (fim_quadro)
   );

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      n_assert++;
      assert (obs === esp) else begin
         n_falha++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, esp);
      end
   endtask

   // One-clk te pulse; returns at the negedge of the first clk after the start edge
   task automatic dispara();
      te = 1'b1;
      @(negedge clk);
      te = 1'b0;
   endtask

   task automatic captura(input int n);
      for (int k = 0; k < n; k++) begin
         onda[k] = dout;
         ocup[k] = ocupado;
         fim[k]  = fim_quadro;
         @(negedge clk);
      end
   endtask

   // High time per half-bit: short = 8 clk, long = 24 clk; sync high = 8 clk
   task automatic verifica_palavra(input int base, input string tag);
      for (int t = 0; t < 12; t++) begin
         for (int h = 0; h < 2; h++) begin
            int c;
            int esp;
            c = 0;
            for (int k = 0; k < 32; k++)
               if (onda[base + t*64 + h*32 + k] === 1'b1) c++;
            esp = ((exp_t[t] == 1) || (exp_t[t] == 2 && h == 1)) ? 24 : 8;
            verifica($sformatf("%s trit%0d half%0d high", tag, t, h), c, esp);
         end
      end
      begin
         int c;
         c = 0;
         for (int k = 0; k < 256; k++)
            if (onda[base + 768 + k] === 1'b1) c++;
         verifica($sformatf("%s sync high", tag), c, 8);
         verifica($sformatf("%s sync start", tag), onda[base + 768], 1'b1);
      end
   endtask

   task automatic verifica_fim(input int nw, input int len, input string tag);
      int c;
      c = 0;
      for (int k = 0; k < len; k++)
         if (fim[k] === 1'b1) c++;
      verifica({tag, " fim count"}, c, nw);
      for (int w = 0; w < nw; w++)
         verifica($sformatf("%s fim word%0d", tag, w), fim[w*PAL + PAL - 1], 1'b1);
      verifica({tag, " ocupado last"}, ocup[nw*PAL - 1], 1'b1);
      verifica({tag, " ocupado after"}, ocup[nw*PAL], 1'b0);
      verifica({tag, " dout after"}, onda[nw*PAL], 1'b0);
   endtask

   task automatic sem_x(input int len, input string tag);
      int nx;
      nx = 0;
      for (int k = 0; k < len; k++)
         if ($isunknown(onda[k])) nx++;
      verifica({tag, " dout X count"}, nx, 0);
   endtask

   initial begin
      // 1. reset
      rst_n = 1'b0;
      te    = 1'b1;
      A_01  = 8'h00;
      A_F   = 8'h00;
      D     = 4'h0;
      repeat (3) @(negedge clk);
      verifica("reset dout", dout, 1'b0);
      verifica("reset ocupado", ocupado, 1'b0);
      verifica("reset fim", fim_quadro, 1'b0);
      te    = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      verifica("idle ocupado", ocupado, 1'b0);
      verifica("idle dout", dout, 1'b0);
      dispara();
      @(negedge clk);
      verifica("mid-trit dout before reset", dout, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      verifica("async reset dout", dout, 1'b0);
      verifica("async reset ocupado", ocupado, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      verifica("post reset ocupado", ocupado, 1'b0);

      // 2. all-zero word
      verifica("t2 dout idle", dout, 1'b0);
      dispara();
      captura(NW1*PAL + 4);
      verifica("t2 latency dout", onda[0], 1'b1);
      verifica("t2 latency ocupado", ocup[0], 1'b1);
      for (int i = 0; i < 12; i++) exp_t[i] = 0;
      verifica_palavra(0, "t2");
      verifica_palavra((NW1 - 1)*PAL, "t2 last");
      verifica_fim(NW1, NW1*PAL + 4, "t2");

      // 3. all address pins floating, value bits unknown, data all ones
      A_F  = 8'hFF;
      A_01 = 8'bxxxx_xxxx;
      D    = 4'hF;
      dispara();
      captura(NW1*PAL + 4);
      for (int i = 0; i < 8; i++) exp_t[i] = 2;
      for (int i = 8; i < 12; i++) exp_t[i] = 1;
      verifica_palavra(0, "t3");
      verifica_fim(NW1, NW1*PAL + 4, "t3");
      sem_x(NW1*PAL + 4, "t3");

      // 4. A=0xA5, D=1001
      A_01 = 8'hA5;
      A_F  = 8'h00;
      D    = 4'b1001;
      dispara();
      A_01 = 8'h00;   // changes after capture are ignored
      D    = 4'h0;
      captura(NW1*PAL + 4);
      exp_t[0] = 1; exp_t[1] = 0; exp_t[2]  = 1; exp_t[3]  = 0;
      exp_t[4] = 0; exp_t[5] = 1; exp_t[6]  = 0; exp_t[7]  = 1;
      exp_t[8] = 1; exp_t[9] = 0; exp_t[10] = 0; exp_t[11] = 1;
      verifica_palavra(0, "t4");
      verifica_fim(NW1, NW1*PAL + 4, "t4");

      // 5. te held across words; D changes mid word 1, te drops mid word 3
      A_01 = 8'h3C;
      A_F  = 8'h81;
      D    = 4'h6;
      te   = 1'b1;
      @(negedge clk);
      for (int k = 0; k < NW5*PAL + 4; k++) begin
         onda[k] = dout;
         ocup[k] = ocupado;
         fim[k]  = fim_quadro;
         if (k == 512)  D  = 4'h1;
         if (k == 2500) te = 1'b0;
         @(negedge clk);
      end
      exp_t[0] = 2; exp_t[1] = 0; exp_t[2]  = 1; exp_t[3]  = 1;
      exp_t[4] = 1; exp_t[5] = 1; exp_t[6]  = 0; exp_t[7]  = 2;
      exp_t[8] = 0; exp_t[9] = 1; exp_t[10] = 1; exp_t[11] = 0;
      verifica_palavra(0, "t5 w1");
      exp_t[8] = 1; exp_t[9] = 0; exp_t[10] = 0; exp_t[11] = 0;
      verifica_palavra(PAL, "t5 w2");
      verifica_palavra(2*PAL, "t5 w3");
      verifica("t5 back-to-back", onda[PAL], 1'b1);
      verifica_fim(NW5, NW5*PAL + 4, "t5");

      // 6. single pulse activation length, then idle
      A_01 = 8'h0F;
      A_F  = 8'h00;
      D    = 4'h3;
      dispara();
      captura(4100);
      verifica_fim(NW1, 4100, "t6");
      verifica("t6 idle at end", ocup[4099], 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_falha);
      $finish;
   end

endmodule
